ps2_scancode_rx_fifo: RTL

//   Parametrised PS/2 device-to-host receiver: synchronises and de-glitches the PS/2 clock/data lines,

---
 rtl/ps2_scancode_rx_fifo_if.sv | 27 ++
 rtl/ps2_scancode_rx_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx_fifo_if.sv
// Bus between a host and the PS/2 scancode receiver: raw line inputs, FIFO pop/clear controls,
// and the FIFO head plus status/error outputs.
`timescale 1ns/1ps
interface ps2_scancode_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          ps2_clk_i;
    logic                          ps2_data_i;
    logic                          rd_en_i;
    logic                          clr_err_i;
    logic [7:0]                    data_o;
    logic                          valid_o;
    logic [$clog2(FIFO_DEPTH):0]   count_o;
    logic                          overflow_o;
    logic                          parity_err_o;
    logic                          frame_err_o;

    modport master (
        output ps2_clk_i, ps2_data_i, rd_en_i, clr_err_i,
        input  data_o, valid_o, count_o, overflow_o, parity_err_o, frame_err_o
    );

    modport slave (
        input  ps2_clk_i, ps2_data_i, rd_en_i, clr_err_i,
        output data_o, valid_o, count_o, overflow_o, parity_err_o, frame_err_o
    );
endinterface

// File: rtl/ps2_scancode_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, de-glitched line inputs, 11-bit frame decode with
// odd parity and inter-edge timeout, good bytes queued in a first-word-fall-through FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a tick)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking the stop bit, pushing or flagging the byte
`timescale 1ns/1ps
module ps2_scancode_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    ps2_scancode_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic          filt_q;
    logic [FW-1:0] filt_cnt;
    logic          differ, tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk_i};
            data_sync <= {data_sync[0], bus.ps2_data_i};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign differ = (clk_s != filt_q);
    // tick fires on the cycle the filtered clock is about to fall, so it aligns with the level change
    assign tick   = differ & filt_q & (filt_cnt == FILT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q   <= 1'b1;
            filt_cnt <= '0;
        end else if (!differ) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_q   <= ~filt_q;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmr_q;
    logic          perr_q, perr_d, ferr_q, ferr_d;
    logic          push, timeout;

    assign timeout = (state_q != S_IDLE) && (tmr_q == '0) && !tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        push      = 1'b0;
        if (timeout) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shreg_d[bit_cnt_q] = data_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = data_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    // a bad stop bit is reported as a framing error regardless of parity
                    if (!data_s)                  ferr_d = 1'b1;
                    else if (^{shreg_q, par_q})   push   = 1'b1;
                    else                          perr_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              tmr_q <= TMR_LOAD;
        else if (state_q == S_IDLE || tick)   tmr_q <= TMR_LOAD;
        else if (tmr_q != '0)                 tmr_q <= tmr_q - TW'(1);
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full, not_empty, pop, wr;

    assign full      = (count_q == CNT_FULL);
    assign not_empty = (count_q != '0);
    assign pop       = bus.rd_en_i & not_empty;
    assign wr        = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shreg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !wr) count_q <= count_q - CW'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
            else if (bus.clr_err_i)   ovf_q <= 1'b0;
        end
    end

    assign bus.data_o       = not_empty ? mem[rd_ptr] : 8'h00;
    assign bus.valid_o      = not_empty;
    assign bus.count_o      = count_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.parity_err_o = perr_q;
    assign bus.frame_err_o  = ferr_q;
endmodule
